fios_result_collector: RTL and testbench



---
 rtl/fios_pkg.sv | 13 +
 rtl/fios_result_collector_if.sv | 27 ++
 rtl/fios_word_subtractor.sv | 21 ++
 rtl/fios_result_collector.sv | 127 ++++++++++++
 tb/tb_fios_result_collector.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/fios_pkg.sv
// Shared types and sizing helpers for the FIOS result collector.
package fios_pkg;

  localparam int WORD_WIDTH = 17;

  typedef logic [WORD_WIDTH-1:0] word_t;

  // Width of the word index counter; kept at least 1 bit for a single-word result.
  function automatic int idx_width(input int word_count);
    return (word_count > 1) ? $clog2(word_count) : 1;
  endfunction

endpackage

// File: rtl/fios_result_collector_if.sv
// Word-in / result-out bus of the FIOS result collector.
// slave: the collector; master: the DSP column plus the result consumer.
interface fios_result_collector_if #(
  parameter int WORD_COUNT = 16
);
  import fios_pkg::*;

  logic                             word_valid_i;
  word_t                            word_i;
  logic [WORD_WIDTH*WORD_COUNT-1:0] modulus_i;
  logic [WORD_WIDTH*WORD_COUNT-1:0] result_o;
  logic                             result_valid_o;
  logic                             result_ready_i;
  logic                             busy_o;
  logic                             overrun_o;

  modport slave (
    input  word_valid_i, word_i, modulus_i, result_ready_i,
    output result_o, result_valid_o, busy_o, overrun_o
  );

  modport master (
    output word_valid_i, word_i, modulus_i, result_ready_i,
    input  result_o, result_valid_o, busy_o, overrun_o
  );

endinterface

// File: rtl/fios_word_subtractor.sv
// One 17-bit subtract-with-borrow slice, used serially across the result words.
// Only built when FIOS_FINAL_SUB_EN is defined; otherwise the file is empty.
`ifdef FIOS_FINAL_SUB_EN
module fios_word_subtractor
  import fios_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  logic  borrow_in,
  output word_t diff,
  output logic  borrow_out
);

  logic [WORD_WIDTH:0] full;

  // Extra top bit of the 18-bit difference is the outgoing borrow.
  assign full = {1'b0, a} - {1'b0, b} - {{WORD_WIDTH{1'b0}}, borrow_in};
  assign {borrow_out, diff} = full;

endmodule
`endif

// File: rtl/fios_result_collector.sv
// FIOS result collector: assembles the LSW-first word stream into a full
// result, optionally applies the Montgomery final subtraction on the fly,
// and holds the result behind a valid/ready handshake.
// Macro FIOS_FINAL_SUB_EN: when defined, builds the subtract path, difference
// buffer and borrow select; when undefined, the raw collected value is output.
module fios_result_collector
  import fios_pkg::*;
#(
  parameter int WORD_COUNT = 16
)(
  input logic                     clock_i,
  input logic                     reset_n_i,
  fios_result_collector_if.slave  bus
);

  localparam int IW = idx_width(WORD_COUNT);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_COUNT - 1);

  typedef logic [WORD_COUNT-1:0][WORD_WIDTH-1:0] buf_t;

  logic [IW-1:0] idx_q, idx_d;
  buf_t          raw_q, raw_d, raw_next;
  buf_t          result_q, result_d, final_val;
  logic          result_valid_q, result_valid_d;
  logic          overrun_q, overrun_d;
  logic          accept, complete;

  assign accept   = bus.word_valid_i;
  assign complete = accept && (idx_q == LAST_IDX);

`ifdef FIOS_FINAL_SUB_EN
  buf_t  diff_q, diff_d, diff_next;
  buf_t  mod_w;
  logic  borrow_q, borrow_d;
  logic  sub_borrow_in, sub_borrow_out;
  word_t sub_diff;

  assign mod_w         = bus.modulus_i;
  // Each result starts a fresh borrow chain at word 0.
  assign sub_borrow_in = (idx_q == '0) ? 1'b0 : borrow_q;

  fios_word_subtractor u_sub (
    .a          (bus.word_i),
    .b          (mod_w[idx_q]),
    .borrow_in  (sub_borrow_in),
    .diff       (sub_diff),
    .borrow_out (sub_borrow_out)
  );

  // Difference buffer and running borrow, advanced per accepted word.
  always_comb begin
    diff_next        = diff_q;
    diff_next[idx_q] = sub_diff;
    diff_d           = diff_q;
    borrow_d         = borrow_q;
    if (accept) begin
      diff_d   = diff_next;
      borrow_d = sub_borrow_out;
    end
  end

  // Final borrow set means raw < M, so the raw value is already reduced.
  assign final_val = sub_borrow_out ? raw_next : diff_next;
`else
  assign final_val = raw_next;
`endif

  // Raw buffer and word index; the buffer view including the current word
  // feeds the output on the completing cycle, giving single-cycle latency.
  always_comb begin
    raw_next        = raw_q;
    raw_next[idx_q] = bus.word_i;
    raw_d           = raw_q;
    idx_d           = idx_q;
    if (accept) begin
      raw_d = raw_next;
      idx_d = complete ? '0 : idx_q + 1'b1;
    end
  end

  // Output handshake: a completion while a result is still held and not being
  // accepted is dropped and flagged; otherwise it loads the output register.
  always_comb begin
    result_d       = result_q;
    result_valid_d = result_valid_q & ~bus.result_ready_i;
    overrun_d      = 1'b0;
    if (complete) begin
      if (result_valid_q && !bus.result_ready_i) begin
        overrun_d = 1'b1;
      end else begin
        result_d       = final_val;
        result_valid_d = 1'b1;
      end
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idx_q          <= '0;
      raw_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef FIOS_FINAL_SUB_EN
      diff_q         <= '0;
      borrow_q       <= 1'b0;
`endif
    end else begin
      idx_q          <= idx_d;
      raw_q          <= raw_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
`ifdef FIOS_FINAL_SUB_EN
      diff_q         <= diff_d;
      borrow_q       <= borrow_d;
`endif
    end
  end

  assign bus.result_o       = result_q;
  assign bus.result_valid_o = result_valid_q;
  assign bus.busy_o         = (idx_q != '0);
  assign bus.overrun_o      = overrun_q;

endmodule

// File: tb/tb_fios_result_collector.sv
// Bench for fios_result_collector with WORD_COUNT=4: an integer-arithmetic
// model checked every cycle, plus hand-computed literal results.
module tb_fios_result_collector;
  import fios_pkg::*;

  localparam int WC = 4;
  localparam int RW = WC * WORD_WIDTH;
`ifdef FIOS_FINAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  localparam logic [RW-1:0] M5   = 68'h5;
  localparam logic [RW-1:0] MBIG = {17'h0F0F0, 17'h00001, 17'h1ABCD, 17'h12345};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;
  int   ovr_seen = 0;

  fios_result_collector_if #(.WORD_COUNT(WC)) bus();

  fios_result_collector #(.WORD_COUNT(WC)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int            m_cnt = 0;
  logic [RW-1:0] m_acc = '0;
  logic [RW-1:0] m_res = '0;
  logic          m_vld = 1'b0;
  logic          m_ovr = 1'b0;

  function automatic logic [RW-1:0] put_word(input logic [RW-1:0] acc, input int i,
                                             input word_t w);
    logic [RW-1:0] t;
    t = acc;
    t[i*WORD_WIDTH +: WORD_WIDTH] = w;
    return t;
  endfunction

  function automatic logic [RW-1:0] reduce(input logic [RW-1:0] raw, input logic [RW-1:0] m);
    if (SUB_EN && raw >= m) return raw - m;
    return raw;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_acc <= '0; m_res <= '0; m_vld <= 1'b0; m_ovr <= 1'b0;
    end else begin
      m_ovr <= 1'b0;
      if (m_vld && bus.result_ready_i) m_vld <= 1'b0;
      if (bus.word_valid_i) begin
        m_acc <= put_word(m_acc, m_cnt, bus.word_i);
        if (m_cnt == WC - 1) begin
          m_cnt <= 0;
          if (m_vld && !bus.result_ready_i) m_ovr <= 1'b1;
          else begin
            m_res <= reduce(put_word(m_acc, m_cnt, bus.word_i), bus.modulus_i);
            m_vld <= 1'b1;
          end
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check1("cyc_valid", bus.result_valid_o, m_vld);
      check1("cyc_busy", bus.busy_o, (m_cnt != 0));
      check1("cyc_overrun", bus.overrun_o, m_ovr);
      if (m_vld) checkw("cyc_result", bus.result_o, m_res);
      if (bus.overrun_o) ovr_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [RW-1:0] v, input bit gap, input bit ready_last);
    for (int i = 0; i < WC; i++) begin
      @(negedge clk);
      if (gap && i == 2) begin
        bus.word_valid_i = 1'b0;
        @(negedge clk);
      end
      bus.word_valid_i = 1'b1;
      bus.word_i       = v[i*WORD_WIDTH +: WORD_WIDTH];
      if (ready_last && i == WC - 1) bus.result_ready_i = 1'b1;
    end
    @(negedge clk);
    bus.word_valid_i = 1'b0;
    if (ready_last) bus.result_ready_i = 1'b0;
  endtask

  task automatic lit(input string name, input logic [RW-1:0] exp, input logic exp_ovr);
    checkw({name, "_result"}, bus.result_o, exp);
    check1({name, "_valid"}, bus.result_valid_o, 1'b1);
    check1({name, "_ovr"}, bus.overrun_o, exp_ovr);
  endtask

  task automatic drain();
    bus.result_ready_i = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.word_valid_i   = 1'b0;
    bus.word_i         = '0;
    bus.modulus_i      = M5;
    bus.result_ready_i = 1'b1;

    #2 rst_n = 1'b0;
    #10;
    check1("rst_valid", bus.result_valid_o, 1'b0);
    check1("rst_busy", bus.busy_o, 1'b0);
    check1("rst_overrun", bus.overrun_o, 1'b0);
    checkw("rst_result", bus.result_o, '0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // result >= M: 7 - 5
    send(68'h7, 1'b0, 1'b0);
    lit("ge", SUB_EN ? 68'h2 : 68'h7, 1'b0);
    repeat (2) @(negedge clk);

    // result < M, with an input gap
    send(68'h3, 1'b1, 1'b0);
    lit("lt", 68'h3, 1'b0);
    repeat (2) @(negedge clk);

    // borrow across words: 0x20002 - 5
    send(68'h20002, 1'b0, 1'b0);
    lit("borrow", SUB_EN ? 68'h1FFFD : 68'h20002, 1'b0);
    repeat (2) @(negedge clk);

    // input equal to a wide M
    bus.modulus_i = MBIG;
    send(MBIG, 1'b0, 1'b0);
    lit("eq", SUB_EN ? 68'h0 : MBIG, 1'b0);
    repeat (2) @(negedge clk);

    // M + 0x10000 carries into word 1
    send({17'h0F0F0, 17'h00001, 17'h1ABCE, 17'h02345}, 1'b0, 1'b0);
    lit("wide", SUB_EN ? 68'h10000 : {17'h0F0F0, 17'h00001, 17'h1ABCE, 17'h02345}, 1'b0);
    repeat (2) @(negedge clk);
    bus.modulus_i = M5;

    // overrun: second result dropped while the first is held
    bus.result_ready_i = 1'b0;
    send(68'h7, 1'b0, 1'b0);
    lit("ovr_first", SUB_EN ? 68'h2 : 68'h7, 1'b0);
    send(68'h3, 1'b0, 1'b0);
    lit("ovr_held", SUB_EN ? 68'h2 : 68'h7, 1'b1);
    drain();
    checki("ovr_count", ovr_seen, 1);

    // accept on the completing edge: second result loads, no overrun
    bus.result_ready_i = 1'b0;
    send(68'h7, 1'b0, 1'b0);
    send(68'h3, 1'b0, 1'b1);
    lit("swap", 68'h3, 1'b0);
    drain();
    checki("swap_ovr_count", ovr_seen, 1);

    // reset mid-collection discards partial words
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.word_valid_i = 1'b1;
      bus.word_i       = 17'h1FFFF;
    end
    @(negedge clk);
    bus.word_valid_i = 1'b0;
    check1("mid_busy", bus.busy_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("mid_rst_busy", bus.busy_o, 1'b0);
    check1("mid_rst_valid", bus.result_valid_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send(68'h7, 1'b0, 1'b0);
    lit("post_rst", SUB_EN ? 68'h2 : 68'h7, 1'b0);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
